// File: rtl/sobel_window_feeder.sv
// Buffers two image lines and feeds 3x3 windows to a gradient detector over the
// start / data_ready handshake, re-emitting each result as a raster-order stream.
module sobel_window_feeder #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_pixel_valid,
  input  logic [7:0] i_pixel,
  output logic       o_pixel_ready,
  output logic       o_gradient_start,
  output logic [7:0] P0,
  output logic [7:0] P1,
  output logic [7:0] P2,
  output logic [7:0] P3,
  output logic [7:0] P4,
  output logic [7:0] P5,
  output logic [7:0] P6,
  output logic [7:0] P7,
  output logic [7:0] P8,
  input  logic       i_gradient_data_ready,
  input  logic [7:0] i_processed_sum,
  output logic       o_result_valid,
  output logic [7:0] o_result,
  output logic       o_frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [2:0] ACCEPT = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic          ready_prev;
  logic          last_window;
  logic          transfer;
  logic          window_valid;
  logic          frame_last;
  logic          ready_rise;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign o_pixel_ready    = n_rst && (state == ACCEPT);
  assign transfer         = i_pixel_valid && o_pixel_ready;
  assign window_valid     = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_last       = (row == ROW_LAST) && (col == COL_LAST);
  assign ready_rise       = i_gradient_data_ready && !ready_prev;
  assign o_gradient_start = (state == LAUNCH);
  assign o_result_valid   = (state == DRAIN) && !i_gradient_data_ready;
  assign o_frame_done     = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      ACCEPT: begin
        if (transfer) begin
          if (window_valid)    next_state = LAUNCH;
          else if (frame_last) next_state = DONE;
        end
      end
      LAUNCH: next_state = WAIT;
      // A data_ready already high on entry is stale; only a fresh rising edge counts.
      WAIT:   if (ready_rise) next_state = DRAIN;
      DRAIN:  if (!i_gradient_data_ready) next_state = last_window ? DONE : ACCEPT;
      DONE:   next_state = ACCEPT;
      default: next_state = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ACCEPT;
      col         <= '0;
      row         <= '0;
      ready_prev  <= 1'b0;
      last_window <= 1'b0;
      o_result    <= '0;
    end else begin
      state      <= next_state;
      ready_prev <= i_gradient_data_ready;
      if (transfer) begin
        last_window <= frame_last;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (state == DONE) begin
        col <= '0;
        row <= '0;
      end
      if ((state == WAIT) && ready_rise) o_result <= i_processed_sum;
    end
  end

  // Window only moves on a transfer, so it stays frozen while a window is in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      P0 <= '0; P1 <= '0; P2 <= '0;
      P3 <= '0; P4 <= '0; P5 <= '0;
      P6 <= '0; P7 <= '0; P8 <= '0;
    end else if (transfer) begin
      lb1[col] <= lb0[col];
      lb0[col] <= i_pixel;
      P0 <= P1; P1 <= P2; P2 <= lb1[col];
      P3 <= P4; P4 <= P5; P5 <= lb0[col];
      P6 <= P7; P7 <= P8; P8 <= i_pixel;
    end
  end

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Scoreboard bench for sobel_window_feeder with a behavioural gradient detector
// answering each start pulse; frames use a 4x4 image.
`timescale 1ns/1ps
module tb_sobel_window_feeder;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       i_pixel_valid;
  logic [7:0] i_pixel;
  logic       o_pixel_ready;
  logic       o_gradient_start;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       det_ready;
  logic [7:0] det_sum;
  logic       o_result_valid;
  logic [7:0] o_result;
  logic       o_frame_done;

  always #5 clk = ~clk;

  sobel_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel),
    .o_pixel_ready(o_pixel_ready), .o_gradient_start(o_gradient_start),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .i_gradient_data_ready(det_ready), .i_processed_sum(det_sum),
    .o_result_valid(o_result_valid), .o_result(o_result), .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    int          idx;
    logic [71:0] win;
  } win_t;

  win_t        win_q[$];
  logic [7:0]  sum_q[$];
  logic [7:0]  img [H][W];
  int          compared = 0;
  int          mismatched = 0;
  int          acc_count = 0;
  int          start_count = 0;
  int          result_count = 0;
  int          done_count = 0;
  bit          inflight = 1'b0;
  int          det_lat = 1;
  int          det_hold = 1;
  bit          det_fixed = 1'b0;
  bit          det_busy = 1'b0;
  logic [71:0] det_win;
  win_t        mon_e;

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gradSum(input logic [71:0] w);
    int p[9];
    int gx, gy, s;
    for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  function automatic logic [71:0] expWindow(input int r, input int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  // Detector model: latency after WAIT entry, then data_ready held det_hold cycles.
  initial begin
    det_ready = 1'b0;
    det_sum   = 8'h00;
    forever begin
      @(negedge clk);
      if (o_gradient_start) begin
        det_busy = 1'b1;
        det_win  = {P0, P1, P2, P3, P4, P5, P6, P7, P8};
        @(posedge clk);
        repeat (det_lat) @(posedge clk);
        #1;
        det_ready = 1'b1;
        det_sum   = det_fixed ? 8'h5A : gradSum(det_win);
        repeat (det_hold) @(posedge clk);
        #1;
        det_ready = 1'b0;
        det_sum   = 8'h00;
        det_busy  = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on start and result pulses.
  always @(negedge clk) begin
    if (!n_rst) begin
      inflight = 1'b0;
    end else begin
      if (o_gradient_start) begin
        start_count++;
        inflight = 1'b1;
        if (win_q.size() == 0) checkOutput("start_unexpected", 1, 0);
        else begin
          mon_e = win_q.pop_front();
          checkOutput("start_idx", acc_count - 1, mon_e.idx);
          checkOutput("window", {P0, P1, P2, P3, P4, P5, P6, P7, P8}, mon_e.win);
        end
      end
      if (inflight) checkOutput("stall_ready", o_pixel_ready, 0);
      if (o_result_valid) begin
        result_count++;
        inflight = 1'b0;
        if (sum_q.size() == 0) checkOutput("result_unexpected", 1, 0);
        else checkOutput("result", o_result, sum_q.pop_front());
      end
      if (o_frame_done) begin
        done_count++;
        checkOutput("done_pending", sum_q.size(), 0);
      end
    end
  end

  task automatic applyStimulus(input int n_pix, input bit rand_valid);
    for (int k = 0; k < n_pix; k++) begin
      bit sent;
      int guard;
      int r, c;
      sent  = 1'b0;
      guard = 0;
      r = k / W;
      c = k % W;
      while (!sent) begin
        @(posedge clk);
        #1;
        i_pixel       = img[r][c];
        i_pixel_valid = (rand_valid && o_pixel_ready) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (i_pixel_valid && o_pixel_ready) begin
          sent = 1'b1;
          acc_count++;
          if (r >= 2 && c >= 2) begin
            win_q.push_back('{idx: k, win: expWindow(r, c)});
            sum_q.push_back(det_fixed ? 8'h5A : gradSum(expWindow(r, c)));
          end
        end else if (++guard > 200) begin
          checkOutput("source_timeout", 0, 1);
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    i_pixel_valid = 1'b0;
  endtask

  task automatic fillImage(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = (c >= 2) ? 8'd255 : 8'd0;
          2:       img[r][c] = 8'(16*r + c);
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic runFrame(input int mode, input bit rand_valid);
    fillImage(mode);
    acc_count = 0; start_count = 0; result_count = 0; done_count = 0;
    applyStimulus(W*H, rand_valid);
    for (int i = 0; i < 400 && done_count == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("frame_starts", start_count, (W-2)*(H-2));
    checkOutput("frame_results", result_count, (W-2)*(H-2));
    checkOutput("frame_done", done_count, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst = 1'b0;
    i_pixel_valid = 1'b0;
    i_pixel = 8'h00;
    #2;
    checkOutput("reset_ctrl", {o_pixel_ready, o_gradient_start, o_result_valid, o_frame_done, o_result}, 0);
    checkOutput("reset_window", {P0, P1, P2, P3, P4, P5, P6, P7, P8}, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", o_pixel_ready, 1);

    runFrame(0, 1'b0);
    runFrame(1, 1'b0);
    det_hold = 5; det_fixed = 1'b1;
    runFrame(2, 1'b0);
    det_hold = 1; det_fixed = 1'b0; det_lat = 2;
    runFrame(3, 1'b1);
    runFrame(3, 1'b1);

    // Abort a frame while the detector is still working on its first window.
    det_lat = 6;
    fillImage(2);
    acc_count = 0; start_count = 0; result_count = 0; done_count = 0;
    applyStimulus(2*W + 3, 1'b0);
    for (int i = 0; i < 50 && start_count == 0; i++) @(negedge clk);
    checkOutput("pre_reset_start", start_count, 1);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    checkOutput("abort_ctrl", {o_pixel_ready, o_gradient_start, o_result_valid, o_frame_done, o_result}, 0);
    checkOutput("abort_window", {P0, P1, P2, P3, P4, P5, P6, P7, P8}, 0);
    win_q.delete();
    sum_q.delete();
    result_count = 0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 50 && det_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("late_result", result_count, 0);
    det_lat = 1;
    runFrame(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sobel_window_feeder.md
Name: sobel_window_feeder

Overview:
- Initiator side of the 3x3 gradient handshake (P0..P8 / start / data_ready / processed_sum).
- Accepts a raster-order 8-bit pixel stream and buffers two image lines. For every complete 3x3 window it presents P0..P8, pulses start, and waits for the gradient result.
- Re-emits each result as a raster-order output stream with a frame-done marker.
- Sits between the pixel source (camera/SRAM reader) and the edge detector.

Parameters:
IMG_WIDTH, 16, pixels per line (>=3); sets line-buffer depth and column counter width
IMG_HEIGHT, 16, lines per frame (>=3); sets row counter width

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
i_pixel_valid  input  1  source pixel valid
i_pixel  input  8  source pixel, raster order
o_pixel_ready  output  1  feeder accepts a pixel this cycle (valid & ready = transfer)
o_gradient_start  output  1  one-cycle start pulse to detector
P0..P8  output  8 each  window to detector: P0-P2 top row, P3-P5 middle, P6-P8 bottom; left to right
i_gradient_data_ready  input  1  detector result-ready (held >=1 cycle, registered with sum)
i_processed_sum  input  8  detector result, valid while data_ready high
o_result_valid  output  1  one-cycle pulse, o_result valid
o_result  output  8  captured gradient value, held until next capture
o_frame_done  output  1  one-cycle pulse after last pixel of the frame is fully handled

Behaviour:
- Reset: all outputs 0; window regs, line buffers, counters cleared; state ACCEPT. Reset mid-operation aborts any in-flight window and the frame restarts at row 0, col 0. A detector result arriving after reset is ignored.
- o_pixel_ready = (state == ACCEPT) only. i_pixel_valid in other states is not accepted; the source must hold.
- On transfer at (row r, col c):
  - top = lb1[c], mid = lb0[c], bot = i_pixel.
  - lb1[c] <= lb0[c]; lb0[c] <= i_pixel.
  - Window shifts left: P0<=P1, P1<=P2, P2<=top; P3<=P4, P4<=P5, P5<=mid; P6<=P7, P7<=P8, P8<=bot.
  - c wraps at IMG_WIDTH-1 and increments r. r wraps at IMG_HEIGHT-1.
- Window valid iff r>=2 and c>=2 for the accepted pixel. This gives (W-2)*(H-2) windows per frame. Windows straddling a line boundary are never launched.
- FSM:
  - ACCEPT: on transfer, if window valid -> LAUNCH. Else if last pixel of frame -> DONE. Else stay.
  - LAUNCH: o_gradient_start=1 for exactly this cycle -> WAIT. P0..P8 stay stable from LAUNCH until leaving DRAIN.
  - WAIT: on i_gradient_data_ready rising edge (previous sample 0, current 1), capture o_result <= i_processed_sum -> DRAIN. No timeout; stays indefinitely.
  - DRAIN: wait until i_gradient_data_ready == 0. On that cycle assert o_result_valid=1. Then -> DONE if the window was the frame's last pixel, else -> ACCEPT. This guarantees the detector is back in IDLE before the next start.
  - DONE: o_frame_done=1 for one cycle; counters reset to 0 (line buffers not cleared) -> ACCEPT.
- Latency: accepted pixel to start pulse = 1 cycle. Start to result_valid = detector latency + ready-high duration + 1.
- Throughput: at most one window in flight. Source is stalled from LAUNCH through DRAIN/DONE.
- Data_ready already high on entry to WAIT (stale) does not count as a rising edge; its falling edge must be seen first.
- Line buffers: 2 x IMG_WIDTH x 8 bits, single write per transfer, registered (flop array acceptable at default size).

Test Plan:
- Reset then W=H=4, flat frame of 16 pixels = 100, detector model returns |Gx|+|Gy| saturated -> exactly 4 o_result_valid pulses, o_result=0 each, one o_frame_done after pixel 16, pixel_ready low from each LAUNCH until its result_valid.
- W=H=4, columns 0-1 = 0, columns 2-3 = 255 -> first window P0=P3=P6=0, P1=P4=P7=0, P2=P5=P8=255; results 255,255,255,255 (saturated).
- Ramp frame pixel = 16*r+c, check P0..P8 at each start equals rows r-2..r, cols c-2..c (first window P0=0,P1=1,P2=2,P3=16,...,P8=34); no start on c<2 or r<2.
- Detector model holds data_ready high 5 cycles with sum 0x5A -> exactly one capture, o_result=0x5A, result_valid once, next start only after data_ready low.
- Source toggles i_pixel_valid randomly and keeps it high during WAIT -> no pixel lost or duplicated; results match golden model for 2 back-to-back frames (second frame uses fresh counters).
- Assert n_rst during WAIT -> all outputs 0 immediately; late data_ready produces no result_valid; next frame starts at (0,0) and first start occurs on pixel index 2*W+2.
